// File: rtl/matmul_pkg.sv
// Constants and FSM encoding shared by the matmul sequencer and writeback stages.
// Pure declarations: no latency, no flow control.
package matmul_pkg;

  localparam int MAT_MUL_SIZE = 8;
  localparam int DWIDTH       = 8;
  localparam int AWIDTH       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tile_counter_2d.sv
// Row-major tile walker: row/col with wrap, last-tile flag, completed-tile count.
// Registered counters with one-cycle update; row_nxt/col_nxt expose the pending value, no backpressure.
module tile_counter_2d #(
  parameter int TILE_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  inc,
  input  logic [TILE_W-1:0]     num_tiles,
  output logic [TILE_W-1:0]     row,
  output logic [TILE_W-1:0]     col,
  output logic [TILE_W-1:0]     row_nxt,
  output logic [TILE_W-1:0]     col_nxt,
  output logic                  last,
  output logic [2*TILE_W-1:0]   tiles_done
);

  logic [TILE_W-1:0] edge_idx;
  logic              col_end;

  assign edge_idx = num_tiles - TILE_W'(1);
  assign col_end  = (col == edge_idx);
  assign last     = col_end && (row == edge_idx);

  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (clr) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (adv) begin
      if (col_end) begin
        col_nxt = '0;
        row_nxt = row + TILE_W'(1);
      end else begin
        col_nxt = col + TILE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      tiles_done <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
      if (clr) begin
        tiles_done <= '0;
      end else if (inc) begin
        tiles_done <= tiles_done + (2*TILE_W)'(1);
      end
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Walks num_tiles x num_tiles output tiles row-major, handshaking each with the systolic array.
// Outputs registered; 2 cycles overhead per tile beyond array latency; start ignored unless idle.
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int TILE_W    = 5,
  parameter int TIMEOUT_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TILE_W-1:0]    num_tiles,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*TILE_W-1:0]  tiles_done,
  output logic                 start_mat_mul,
  input  logic                 done_mat_mul,
  output logic [AWIDTH-1:0]    a_loc,
  output logic [AWIDTH-1:0]    b_loc,
  output logic [7:0]           final_mat_mul_size
);

  // Last WAIT cycle before the watchdog would reach 2^TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  seq_state_t          state, state_nxt;
  logic [TILE_W-1:0]   n_lat;
  logic [TIMEOUT_W-1:0] wdog;
  logic                accept, timeout, tile_ok, cnt_adv;
  logic [TILE_W-1:0]   row, col, row_nxt, col_nxt;
  logic                last;
  logic [7:0]          size_nxt;

  assign size_nxt = 8'(num_tiles * MAT_MUL_SIZE);

  tile_counter_2d #(.TILE_W(TILE_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (accept),
    .adv        (cnt_adv),
    .inc        (tile_ok),
    .num_tiles  (n_lat),
    .row        (row),
    .col        (col),
    .row_nxt    (row_nxt),
    .col_nxt    (col_nxt),
    .last       (last),
    .tiles_done (tiles_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A done from the array on the watchdog's final cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    timeout   = 1'b0;
    tile_ok   = 1'b0;
    cnt_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (num_tiles == '0) ? FINISH : WAIT;
        end
      end
      WAIT: begin
        if (done_mat_mul) begin
          tile_ok   = 1'b1;
          state_nxt = GAP;
        end else if (wdog == WDOG_LAST) begin
          timeout   = 1'b1;
          state_nxt = FINISH;
        end
      end
      GAP: begin
        cnt_adv   = 1'b1;
        state_nxt = last ? FINISH : WAIT;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      n_lat              <= '0;
      wdog               <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      start_mat_mul      <= 1'b0;
      a_loc              <= '0;
      b_loc              <= '0;
      final_mat_mul_size <= '0;
    end else begin
      wdog          <= (state == WAIT) ? wdog + TIMEOUT_W'(1) : '0;
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == FINISH);
      start_mat_mul <= (state_nxt == WAIT);
      if (accept) begin
        n_lat              <= num_tiles;
        final_mat_mul_size <= size_nxt;
        err                <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
      // Locations follow the counter's pending value so they are valid with start_mat_mul.
      if (state_nxt == WAIT) begin
        a_loc <= AWIDTH'(row_nxt);
        b_loc <= AWIDTH'(col_nxt);
      end
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench: runs push expected tile windows and done reports; a monitor pops and compares.
module tb_matmul_tile_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] num_tiles;
  logic       busy, done, err;
  logic [9:0] tiles_done;
  logic       start_mat_mul;
  logic       done_mat_mul;
  logic [7:0] a_loc, b_loc, final_mat_mul_size;

  localparam int TMO_WIN = 63;  // 2^6 - 1 WAIT cycles before timeout

  matmul_tile_sequencer #(.TILE_W(5), .TIMEOUT_W(6)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .num_tiles          (num_tiles),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .tiles_done         (tiles_done),
    .start_mat_mul      (start_mat_mul),
    .done_mat_mul       (done_mat_mul),
    .a_loc              (a_loc),
    .b_loc              (b_loc),
    .final_mat_mul_size (final_mat_mul_size)
  );

  typedef struct {
    int a;
    int b;
    int size;
    int win;
    bit first;
  } tile_t;

  typedef struct {
    int err;
    int tiles;
  } done_t;

  tile_t tq[$];
  done_t dq[$];

  int n_vec = 0;
  int n_fail = 0;
  bit aborting = 1'b1;

  // array model: 0 = done after arr_lat cycles, 1 = never done, 2 = done stuck high
  int arr_mode = 0;
  int arr_lat = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int acnt;
    acnt = 0;
    done_mat_mul = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (start_mat_mul) acnt++;
      else acnt = 0;
      done_mat_mul = (arr_mode == 2) || (arr_mode == 0 && start_mat_mul && acnt >= arr_lat);
    end
  end

  // Reference model: what one run should produce, from the walk rules alone.
  task automatic push_run(input int n, input int mode, input int lat);
    tile_t t;
    done_t d;
    int win;
    win = (mode == 2) ? 1 : (mode == 1) ? TMO_WIN : lat;
    if (mode == 1 && n > 0) begin
      t.a = 0; t.b = 0; t.size = (n * 8) % 256; t.win = win; t.first = 1'b1;
      tq.push_back(t);
      d.err = 1;
      d.tiles = 0;
    end else begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          t.a = r; t.b = c; t.size = (n * 8) % 256; t.win = win;
          t.first = (r == 0 && c == 0);
          tq.push_back(t);
        end
      end
      d.err = 0;
      d.tiles = n * n;
    end
    dq.push_back(d);
  endtask

  task automatic run(input int n, input int mode, input int lat, input bit noisy);
    int cyc;
    arr_mode = mode;
    arr_lat = lat;
    push_run(n, mode, lat);
    start = 1'b1;
    num_tiles = 5'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", int'(busy), 1);
    if (n == 0) begin
      chk("zero_done_next", int'(done), 1);
      chk("zero_no_smm", int'(start_mat_mul), 0);
    end else begin
      chk("accept_smm", int'(start_mat_mul), 1);
    end
    cyc = 0;
    while (busy && cyc < 20000) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        num_tiles = 5'($urandom_range(0, 31));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 20000) chk("run_timeout", cyc, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_tiles_done", int'(tiles_done), 0);
    chk("rst_smm", int'(start_mat_mul), 0);
    chk("rst_a_loc", int'(a_loc), 0);
    chk("rst_b_loc", int'(b_loc), 0);
    chk("rst_size", int'(final_mat_mul_size), 0);
  endtask

  // Monitor: tile windows (rise/fall of start_mat_mul) and done pulses.
  initial begin
    tile_t et;
    done_t ed;
    bit prev_smm, prev_done;
    int win_len, low_len, cur_win;
    prev_smm = 0; prev_done = 0; win_len = 0; low_len = 0; cur_win = 0;
    forever begin
      @(negedge clk);
      if (aborting) begin
        prev_smm = 0; prev_done = 0; win_len = 0; low_len = 0;
      end else begin
        if (start_mat_mul && !prev_smm) begin
          if (tq.size() == 0) begin
            chk("unexpected_tile", 1, 0);
            cur_win = -1;
          end else begin
            et = tq.pop_front();
            chk("a_loc", int'(a_loc), et.a);
            chk("b_loc", int'(b_loc), et.b);
            chk("final_size", int'(final_mat_mul_size), et.size);
            if (!et.first) chk("gap_len", low_len, 1);
            cur_win = et.win;
          end
          win_len = 0;
        end
        if (start_mat_mul) win_len++;
        if (!start_mat_mul && prev_smm) begin
          chk("window_len", win_len, cur_win);
          low_len = 0;
        end
        if (!start_mat_mul) low_len++;
        if (prev_done) begin
          chk("done_one_cycle", int'(done), 0);
          chk("busy_after_done", int'(busy), 0);
        end
        if (done) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            ed = dq.pop_front();
            chk("done_err", int'(err), ed.err);
            chk("done_tiles", int'(tiles_done), ed.tiles);
            chk("done_busy", int'(busy), 1);
          end
        end
        prev_smm = start_mat_mul;
        prev_done = done;
      end
    end
  end

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    num_tiles = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;
    @(negedge clk);
    #1;
    aborting = 1'b0;

    run(2, 0, 20, 1'b0);
    run(0, 0, 1, 1'b0);
    run(1, 0, 1, 1'b0);
    run(3, 0, $urandom_range(1, 12), 1'b1);
    run(1, 0, TMO_WIN, 1'b0);
    run(2, 1, 1, 1'b0);
    chk("err_sticky", int'(err), 1);
    run(2, 0, 5, 1'b0);
    chk("err_cleared", int'(err), 0);
    run(3, 2, 1, 1'b0);

    // Abort partway through tile (1,0) of a 3x3 run.
    arr_mode = 0;
    arr_lat = 10;
    push_run(3, 0, 10);
    start = 1'b1;
    num_tiles = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!(start_mat_mul && a_loc == 8'd1 && b_loc == 8'd0) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 500) chk("abort_wait", cyc, 0);
    repeat (3) @(posedge clk);
    #1;
    aborting = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;
    tq.delete();
    dq.delete();
    @(negedge clk);
    #1;
    aborting = 1'b0;
    run(1, 0, 4, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run($urandom_range(0, 6), ($urandom_range(0, 3) == 0) ? 2 : 0,
          $urandom_range(1, 40), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("tiles_left", tq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
